// File: rtl/loadable_memory.sv
`default_nettype none
// ============================================================================
// Module : loadable_memory
// Unified program/data memory with a valid/ready program loader that holds the
// processor idle until the image is in. Optional macro: LOAD_CHECKSUM_EN.
// Rev    : 1.0
// ============================================================================
module loadable_memory #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4096,
  parameter int AW    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ld_start,
  input  logic [AW:0]      ld_len,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  output logic             ld_ready,
  output logic             ld_busy,
  output logic             ld_err,
  output logic             core_run,
  input  logic [AW-1:0]    core_addr,
  output logic [WIDTH-1:0] core_rdata,
  input  logic             core_we,
  input  logic [WIDTH-1:0] core_wdata,
  output logic             addr_err
);

  localparam int          c_iw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

`ifdef LOAD_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2, S_CHECK = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2} state_t;
`endif

  state_t           r_state;
  logic [AW:0]      r_ptr;
  logic [AW:0]      r_len;
  logic             r_err;
  logic             r_addr_err;
  logic [WIDTH-1:0] r_mem [DEPTH];
`ifdef LOAD_CHECKSUM_EN
  logic [WIDTH-1:0] r_sum;
`endif

  logic w_addr_ok;
  logic w_ld_we;
  logic w_core_we;
  logic w_last;

  // Compare at AW+1 bits so DEPTH == 2^AW is representable.
  assign w_addr_ok = ({1'b0, core_addr} < c_depth);
  assign w_ld_we   = (r_state == S_LOAD) && ld_valid;
  assign w_core_we = (r_state == S_RUN) && core_we && w_addr_ok;
  assign w_last    = (r_ptr == (r_len - (AW+1)'(1)));

`ifdef LOAD_CHECKSUM_EN
  assign ld_ready = (r_state == S_LOAD) || (r_state == S_CHECK);
`else
  assign ld_ready = (r_state == S_LOAD);
`endif
  assign ld_busy    = ld_ready;
  assign core_run   = (r_state == S_RUN);
  assign ld_err     = r_err;
  assign addr_err   = r_addr_err;
  assign core_rdata = w_addr_ok ? r_mem[core_addr[c_iw-1:0]] : '0;

  // Storage is deliberately unreset so a reset does not wipe a loaded image.
  always_ff @(posedge clk) begin
    if (w_ld_we) begin
      r_mem[r_ptr[c_iw-1:0]] <= ld_data;
    end else if (w_core_we) begin
      r_mem[core_addr[c_iw-1:0]] <= core_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_len      <= '0;
      r_err      <= 1'b0;
      r_addr_err <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      r_addr_err <= (r_state == S_RUN) && !w_addr_ok;
      case (r_state)
        // RUN shares the start check so a reload can be requested mid-execution.
        S_IDLE, S_RUN: begin
          if (ld_start) begin
            if (ld_len == '0) begin
              r_state <= S_RUN;
            end else if (ld_len > c_depth) begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_len   <= ld_len;
              r_ptr   <= '0;
              r_err   <= 1'b0;
              r_state <= S_LOAD;
`ifdef LOAD_CHECKSUM_EN
              r_sum   <= '0;
`endif
            end
          end
        end
        S_LOAD: begin
          if (ld_valid) begin
            r_ptr <= r_ptr + (AW+1)'(1);
`ifdef LOAD_CHECKSUM_EN
            r_sum <= r_sum + ld_data;
            if (w_last) r_state <= S_CHECK;
`else
            if (w_last) r_state <= S_RUN;
`endif
          end
        end
`ifdef LOAD_CHECKSUM_EN
        S_CHECK: begin
          if (ld_valid) begin
            if (ld_data == r_sum) begin
              r_state <= S_RUN;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
